// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: phase sequencer for a two-road intersection with a
// pedestrian walk phase and a night flashing mode. It sits between the board
// inputs (sensor, button, switch) and the 5-bit countdown Timer.
//
// Timer load handshake: start_timer is a single-cycle pulse and value is only
// meaningful while start_timer=1 (it reads 0 otherwise). There is no back-pressure:
// the Timer always accepts the load on that edge. Completion comes back as the
// level signal expired. That signal is trusted only from the second WAIT cycle
// onward, because the Timer clears a stale expired one cycle after it samples
// the load.
module traffic_light_ctrl #(
    parameter logic [4:0] T_BASE = 5'd6,
    parameter logic [4:0] T_EXT  = 5'd3,
    parameter logic [4:0] T_YEL  = 5'd2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sensor,
    input  logic       walk_request,
    input  logic       night,
    input  logic       expired,
    input  logic       one_hz_enable,
    output logic [4:0] value,
    output logic       start_timer,
    output logic [2:0] main_lights,
    output logic [2:0] side_lights,
    output logic       walk_light,
    output logic [3:0] fsm_state
);

    typedef enum logic [3:0] {
        S_INIT, S_MG, S_MGX, S_MY, S_WALK, S_SG, S_SGX, S_SY, S_FLASH
    } state_t;

    // LOAD issues the Timer pulse; WAIT1 is the blind cycle; WAIT honours expired.
    typedef enum logic [1:0] {PH_LOAD, PH_WAIT1, PH_WAIT} phase_t;

    state_t     state, state_next;
    phase_t     phase, phase_next;
    logic       walk_pending, walk_pending_next;
    logic       flash_on, flash_on_next;
    logic [4:0] duration;

    assign fsm_state = state;

    // State, sub-phase, pending walk and flash phase registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_INIT;
            phase        <= PH_LOAD;
            walk_pending <= 1'b0;
            flash_on     <= 1'b1;
        end else begin
            state        <= state_next;
            phase        <= phase_next;
            walk_pending <= walk_pending_next;
            flash_on     <= flash_on_next;
        end
    end

    // Next state: sub-phase stepping, expiry decisions, night mode and walk latch.
    always_comb begin
        state_next        = state;
        phase_next        = phase;
        walk_pending_next = walk_pending;
        flash_on_next     = flash_on;

        if (walk_request && state != S_WALK) begin
            walk_pending_next = 1'b1;
        end

        case (state)
            S_INIT: state_next = S_MG;
            S_FLASH: begin
                // Leave through main yellow so main traffic never jumps to green.
                if (!night) begin
                    state_next = S_MY;
                end else if (one_hz_enable) begin
                    flash_on_next = ~flash_on;
                end
            end
            default: begin
                case (phase)
                    PH_LOAD:  phase_next = PH_WAIT1;
                    PH_WAIT1: phase_next = PH_WAIT;
                    default: begin
                        if (expired) begin
                            case (state)
                                S_MG:    state_next = night ? S_FLASH : (sensor ? S_MY : S_MGX);
                                S_MGX:   state_next = S_MY;
                                // A request in the expiry cycle itself still counts.
                                S_MY:    state_next = (walk_pending || walk_request) ? S_WALK : S_SG;
                                S_WALK:  state_next = S_SG;
                                S_SG:    state_next = sensor ? S_SGX : S_SY;
                                S_SGX:   state_next = S_SY;
                                S_SY:    state_next = S_MG;
                                default: state_next = S_INIT;
                            endcase
                        end
                    end
                endcase
            end
        endcase

        // Every state entry starts in LOAD with the flasher at its lit phase.
        if (state_next != state) begin
            phase_next    = PH_LOAD;
            flash_on_next = 1'b1;
            if (state_next == S_WALK) begin
                walk_pending_next = 1'b0;
            end
        end
    end

    // Output decode from registered state only: lamps, walk lamp, Timer load.
    always_comb begin
        main_lights = 3'b100;
        side_lights = 3'b100;
        walk_light  = 1'b0;
        duration    = 5'd0;
        case (state)
            S_MG:   begin main_lights = 3'b001; duration = T_BASE; end
            S_MGX:  begin main_lights = 3'b001; duration = T_EXT;  end
            S_MY:   begin main_lights = 3'b010; duration = T_YEL;  end
            S_WALK: begin walk_light  = 1'b1;   duration = T_EXT;  end
            S_SG:   begin side_lights = 3'b001; duration = T_BASE; end
            S_SGX:  begin side_lights = 3'b001; duration = T_EXT;  end
            S_SY:   begin side_lights = 3'b010; duration = T_YEL;  end
            S_FLASH: begin
                main_lights = flash_on ? 3'b010 : 3'b000;
                side_lights = flash_on ? 3'b010 : 3'b000;
            end
            default: ;
        endcase
        start_timer = (state != S_INIT) && (state != S_FLASH) && (phase == PH_LOAD);
        value       = start_timer ? duration : 5'd0;
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: directed phase table, hand-written night/reset
// sequences, and a randomized run against a phase-level reference model,
// driving the controller through a behavioural countdown timer.
module tb_traffic_light_ctrl;

    localparam logic [4:0] T_BASE = 5'd6;
    localparam logic [4:0] T_EXT  = 5'd3;
    localparam logic [4:0] T_YEL  = 5'd2;

    logic       clock = 1'b0;
    logic       reset;
    logic       sensor = 1'b0;
    logic       walk_request = 1'b0;
    logic       night = 1'b0;
    logic       expired;
    logic       one_hz_enable;
    logic [4:0] value;
    logic       start_timer;
    logic [2:0] main_lights;
    logic [2:0] side_lights;
    logic       walk_light;
    logic [3:0] fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    traffic_light_ctrl #(.T_BASE(T_BASE), .T_EXT(T_EXT), .T_YEL(T_YEL)) dut (
        .clock         (clock),
        .reset         (reset),
        .sensor        (sensor),
        .walk_request  (walk_request),
        .night         (night),
        .expired       (expired),
        .one_hz_enable (one_hz_enable),
        .value         (value),
        .start_timer   (start_timer),
        .main_lights   (main_lights),
        .side_lights   (side_lights),
        .walk_light    (walk_light),
        .fsm_state     (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- behavioural Timer with a fast tick ----------------
    logic [1:0] tick_div = 2'd0;
    logic [4:0] tcnt     = 5'd0;
    logic       tmr_exp  = 1'b0;
    logic       force_exp = 1'b0;

    assign one_hz_enable = (tick_div == 2'd2);
    assign expired       = tmr_exp | force_exp;

    always @(posedge clock) begin
        tick_div <= (tick_div == 2'd2) ? 2'd0 : tick_div + 2'd1;
        if (start_timer) begin
            tcnt    <= value;
            tmr_exp <= 1'b0;
        end else if (one_hz_enable && tcnt != 5'd0) begin
            tcnt <= tcnt - 5'd1;
            if (tcnt == 5'd1) tmr_exp <= 1'b1;
        end
    end

    // ---------------- phase-level reference model ----------------
    typedef enum int {P_INIT, P_MG, P_MGX, P_MY, P_WALK, P_SG, P_SGX, P_SY, P_FLASH} ph_t;

    function automatic ph_t rule_next(ph_t p, bit sen, bit nig, bit pend);
        case (p)
            P_MG:    return nig ? P_FLASH : (sen ? P_MY : P_MGX);
            P_MGX:   return P_MY;
            P_MY:    return pend ? P_WALK : P_SG;
            P_WALK:  return P_SG;
            P_SG:    return sen ? P_SGX : P_SY;
            P_SGX:   return P_SY;
            P_SY:    return P_MG;
            default: return p;
        endcase
    endfunction

    function automatic logic [4:0] dur_of(ph_t p);
        case (p)
            P_MG, P_SG:           return T_BASE;
            P_MGX, P_SGX, P_WALK: return T_EXT;
            P_MY, P_SY:           return T_YEL;
            default:              return 5'd0;
        endcase
    endfunction

    ph_t  m_ph, m_nxt;
    int   m_k;        // cycles already spent in the current phase
    bit   m_pend;
    bit   m_flash;

    always_comb begin
        m_nxt = m_ph;
        if (m_ph == P_INIT) m_nxt = P_MG;
        else if (m_ph == P_FLASH) begin
            if (!night) m_nxt = P_MY;
        end else if (m_k >= 2 && expired)
            m_nxt = rule_next(m_ph, sensor, night, m_pend || walk_request);
    end

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_ph <= P_INIT; m_k <= 0; m_pend <= 1'b0; m_flash <= 1'b1;
        end else begin
            m_ph    <= m_nxt;
            m_k     <= (m_nxt != m_ph) ? 0 : ((m_k < 7) ? m_k + 1 : m_k);
            m_pend  <= (m_nxt == P_WALK && m_ph != P_WALK) ? 1'b0 :
                       ((walk_request && m_ph != P_WALK) ? 1'b1 : m_pend);
            m_flash <= (m_nxt != m_ph) ? 1'b1 :
                       ((m_ph == P_FLASH && one_hz_enable) ? ~m_flash : m_flash);
        end
    end

    logic [2:0] em, es;
    logic       ew, est;
    logic [4:0] ev;
    always_comb begin
        em = 3'b100; es = 3'b100; ew = 1'b0;
        case (m_ph)
            P_MG, P_MGX: em = 3'b001;
            P_MY:        em = 3'b010;
            P_WALK:      ew = 1'b1;
            P_SG, P_SGX: es = 3'b001;
            P_SY:        es = 3'b010;
            P_FLASH: begin em = m_flash ? 3'b010 : 3'b000; es = em; end
            default: ;
        endcase
        est = (m_ph != P_INIT) && (m_ph != P_FLASH) && (m_k == 0);
        ev  = est ? dur_of(m_ph) : 5'd0;
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    bit check_en = 1'b0;
    always @(negedge clock) begin
        if (check_en)
            check("model", {19'd0, main_lights, side_lights, walk_light, start_timer, value},
                           {19'd0, em, es, ew, est, ev});
    end

    task automatic wait_load(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (start_timer) begin ok = 1'b1; break; end
        end
    endtask

    // ---------------- directed phase table ----------------
    typedef struct {
        bit         sen;
        bit         pulse;
        logic [4:0] val;
        logic [2:0] mainl;
        logic [2:0] sidel;
        bit         walk;
    } row_t;
    row_t rows[19];

    bit         ok;
    bit         found;
    logic [2:0] exp_fl;
    int         walk_len;

    initial begin
        rows[0]  = '{0, 0, 5'd3, 3'b001, 3'b100, 0};  // MGX
        rows[1]  = '{0, 0, 5'd2, 3'b010, 3'b100, 0};  // MY
        rows[2]  = '{0, 0, 5'd6, 3'b100, 3'b001, 0};  // SG
        rows[3]  = '{0, 0, 5'd2, 3'b100, 3'b010, 0};  // SY
        rows[4]  = '{1, 0, 5'd6, 3'b001, 3'b100, 0};  // MG, sensor now high
        rows[5]  = '{1, 0, 5'd2, 3'b010, 3'b100, 0};  // MY directly
        rows[6]  = '{1, 0, 5'd6, 3'b100, 3'b001, 0};  // SG
        rows[7]  = '{1, 0, 5'd3, 3'b100, 3'b001, 0};  // SGX
        rows[8]  = '{0, 0, 5'd2, 3'b100, 3'b010, 0};  // SY
        rows[9]  = '{0, 1, 5'd6, 3'b001, 3'b100, 0};  // MG, walk pulse follows
        rows[10] = '{0, 0, 5'd3, 3'b001, 3'b100, 0};  // MGX
        rows[11] = '{0, 0, 5'd2, 3'b010, 3'b100, 0};  // MY
        rows[12] = '{0, 0, 5'd3, 3'b100, 3'b100, 1};  // WALK
        rows[13] = '{0, 0, 5'd6, 3'b100, 3'b001, 0};  // SG
        rows[14] = '{0, 0, 5'd2, 3'b100, 3'b010, 0};  // SY
        rows[15] = '{0, 0, 5'd6, 3'b001, 3'b100, 0};  // MG
        rows[16] = '{0, 0, 5'd3, 3'b001, 3'b100, 0};  // MGX
        rows[17] = '{0, 0, 5'd2, 3'b010, 3'b100, 0};  // MY
        rows[18] = '{0, 0, 5'd6, 3'b100, 3'b001, 0};  // SG, no second WALK

        // ---- reset and startup ----
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("rst_lights", {main_lights, side_lights, walk_light}, {3'b100, 3'b100, 1'b0});
            check("rst_timer", {start_timer, value}, 6'd0);
        end
        @(posedge clock); #1 reset = 1'b1;
        check_en = 1'b1;
        @(negedge clock);
        check("init_lights", {main_lights, side_lights, start_timer}, {3'b100, 3'b100, 1'b0});
        @(negedge clock);
        check("mg_load", {start_timer, value}, {1'b1, 5'd6});
        check("mg_main", main_lights, 3'b001);

        // ---- table: full cycle, sensor extension, walk ----
        for (int r = 0; r < 19; r++) begin
            sensor = rows[r].sen;
            wait_load(ok);
            check($sformatf("row%0d_seen", r), ok, 1);
            check($sformatf("row%0d_value", r), value, rows[r].val);
            check($sformatf("row%0d_lights", r), {main_lights, side_lights, walk_light},
                  {rows[r].mainl, rows[r].sidel, rows[r].walk});
            if (rows[r].pulse) begin
                walk_request = 1'b1;
                @(negedge clock);
                walk_request = 1'b0;
            end
        end

        // ---- night mode ----
        night = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (main_lights == 3'b010 && side_lights == 3'b010) begin found = 1'b1; break; end
        end
        check("flash_entry", found, 1);
        exp_fl = 3'b010;
        for (int t = 0; t < 4; t++) begin
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                check("flash_no_load", {start_timer, walk_light}, 2'b00);
                if (one_hz_enable) begin ok = 1'b1; break; end
                @(negedge clock);
            end
            check("flash_tick_seen", ok, 1);
            @(negedge clock);
            exp_fl = exp_fl ^ 3'b010;
            check($sformatf("flash_toggle%0d", t), {main_lights, side_lights}, {exp_fl, exp_fl});
        end
        night = 1'b0;
        @(negedge clock);
        check("flash_exit_my", {start_timer, value, main_lights, side_lights},
              {1'b1, 5'd2, 3'b010, 3'b100});
        wait_load(ok);
        check("after_flash_sg", {ok, value, main_lights, side_lights},
              {1'b1, 5'd6, 3'b100, 3'b001});

        // ---- reset mid-phase with stale expired ----
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b0;
        #1 check("midrst_lights", {main_lights, side_lights, walk_light}, {3'b100, 3'b100, 1'b0});
        check("midrst_timer", {start_timer, value}, 6'd0);
        force_exp = 1'b1;
        @(posedge clock);
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock);
        check("midrst_init", {main_lights, start_timer}, {3'b100, 1'b0});
        @(negedge clock);
        check("midrst_mg_load", {start_timer, value, main_lights}, {1'b1, 5'd6, 3'b001});
        @(negedge clock);
        check("midrst_mg_held", {start_timer, main_lights}, {1'b0, 3'b001});
        force_exp = 1'b0;

        // ---- randomized run against the model ----
        walk_len = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if ($urandom_range(0, 7) == 0) sensor = 1'($urandom_range(0, 1));
            if (walk_len == 0 && $urandom_range(0, 39) == 0) walk_len = $urandom_range(1, 30);
            walk_request = (walk_len > 0);
            if (walk_len > 0) walk_len--;
            if ($urandom_range(0, 199) == 0) night = ~night;
        end
        night = 1'b0;
        walk_request = 1'b0;
        repeat (10) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
